// File: rtl/apb_axi_bridge_pkg.sv
// Shared definitions for the APB4-to-AXI4-Lite bridge: FSM state encodings,
// AXI response codes and small helper functions.
// Ports: none (package).
package apb_axi_bridge_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REQ  = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_RESP = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Subtract-then-compare keeps the test correct even if the window is
  // placed against the top of the address space.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    return (addr - base) < size;
  endfunction

  // EXOKAY is folded into success; only SLVERR/DECERR flag an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    logic err;
    err = 1'b0;
    case (resp)
      RESP_OKAY, RESP_EXOKAY:   err = 1'b0;
      RESP_SLVERR, RESP_DECERR: err = 1'b1;
      default:                  err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/apb_axi_bridge_if.sv
// Bundle of the APB4 completer signals and AXI4-Lite master signals around
// the bridge. 'slave' is the bridge's own view (APB completer, AXI driver);
// 'master' is the surrounding system's view (APB initiator, AXI target).
interface apb_axi_bridge_if;

  logic [31:0] s_apb_paddr;
  logic [2:0]  s_apb_pprot;
  logic        s_apb_psel;
  logic        s_apb_penable;
  logic        s_apb_pwrite;
  logic [31:0] s_apb_pwdata;
  logic [3:0]  s_apb_pstrb;
  logic        s_apb_pready;
  logic [31:0] s_apb_prdata;
  logic        s_apb_pslverr;

  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  modport slave (
    input  s_apb_paddr, s_apb_pprot, s_apb_psel, s_apb_penable,
    input  s_apb_pwrite, s_apb_pwdata, s_apb_pstrb,
    output s_apb_pready, s_apb_prdata, s_apb_pslverr,
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready
  );

  modport master (
    output s_apb_paddr, s_apb_pprot, s_apb_psel, s_apb_penable,
    output s_apb_pwrite, s_apb_pwdata, s_apb_pstrb,
    input  s_apb_pready, s_apb_prdata, s_apb_pslverr,
    input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready
  );

endinterface

// File: rtl/apb_axi_bridge.sv
// APB4 completer that turns each APB transfer into one AXI4-Lite transaction;
// out-of-window addresses complete locally with pslverr and no AXI traffic.
// Ports: s_apb_clk, s_apb_areset (async, active-high), bus (slave modport).
module apb_axi_bridge
  import apb_axi_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] WINDOW_SIZE = 32'h0001_0000
) (
  input  logic            s_apb_clk,
  input  logic            s_apb_areset,
  apb_axi_bridge_if.slave bus
);

  logic [2:0]  state;
  logic [31:0] addr_q;
  logic [2:0]  prot_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic        aw_done;
  logic        w_done;
  logic        pready_q;
  logic        pslverr_q;
  logic [31:0] prdata_q;

  logic setup;
  logic aw_hs;
  logic w_hs;

  // Only a setup phase is acted on; access-phase beats are ignored.
  assign setup = bus.s_apb_psel && !bus.s_apb_penable;
  assign aw_hs = bus.m_axi_awvalid && bus.m_axi_awready;
  assign w_hs  = bus.m_axi_wvalid  && bus.m_axi_wready;

  // Valids and readies decode straight from flops, so an async reset
  // drops them in the same cycle.
  assign bus.m_axi_awvalid = (state == ST_WR_REQ) && !aw_done;
  assign bus.m_axi_wvalid  = (state == ST_WR_REQ) && !w_done;
  assign bus.m_axi_bready  = (state == ST_WR_RESP);
  assign bus.m_axi_arvalid = (state == ST_RD_REQ);
  assign bus.m_axi_rready  = (state == ST_RD_RESP);

  assign bus.m_axi_awaddr = addr_q;
  assign bus.m_axi_awprot = prot_q;
  assign bus.m_axi_araddr = addr_q;
  assign bus.m_axi_arprot = prot_q;
  assign bus.m_axi_wdata  = wdata_q;
  assign bus.m_axi_wstrb  = strb_q;

  assign bus.s_apb_pready  = pready_q;
  assign bus.s_apb_pslverr = pslverr_q;
  assign bus.s_apb_prdata  = prdata_q;

  always_ff @(posedge s_apb_clk or posedge s_apb_areset) begin
    if (s_apb_areset) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      prot_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (setup) begin
            addr_q  <= bus.s_apb_paddr;
            prot_q  <= bus.s_apb_pprot;
            wdata_q <= bus.s_apb_pwdata;
            strb_q  <= bus.s_apb_pstrb;
            if (!in_window(bus.s_apb_paddr, BASE_ADDR, WINDOW_SIZE)) begin
              state     <= ST_DONE;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
              prdata_q  <= '0;
            end else if (bus.s_apb_pwrite) begin
              state <= ST_WR_REQ;
            end else begin
              state <= ST_RD_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          // AW and W complete independently, possibly in the same cycle.
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state   <= ST_WR_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        ST_WR_RESP: begin
          if (bus.m_axi_bvalid) begin
            state     <= ST_DONE;
            pready_q  <= 1'b1;
            pslverr_q <= resp_is_err(bus.m_axi_bresp);
            prdata_q  <= '0;
          end
        end
        ST_RD_REQ: begin
          if (bus.m_axi_arready) state <= ST_RD_RESP;
        end
        ST_RD_RESP: begin
          if (bus.m_axi_rvalid) begin
            state     <= ST_DONE;
            pready_q  <= 1'b1;
            pslverr_q <= resp_is_err(bus.m_axi_rresp);
            prdata_q  <= bus.m_axi_rdata;
          end
        end
        ST_DONE: begin
          // Completion is a one-cycle pulse whether or not psel is still high.
          state     <= ST_IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_axi_bridge.sv
// Directed bench for apb_axi_bridge: APB initiator tasks plus a latency-
// programmable AXI4-Lite target that also records handshakes for checking.
module tb_apb_axi_bridge;
  import apb_axi_bridge_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_axi_bridge_if bus();

  apb_axi_bridge #(.BASE_ADDR(32'h0000_0000), .WINDOW_SIZE(32'h0001_0000)) dut (
    .s_apb_clk   (clk),
    .s_apb_areset(rst),
    .bus         (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // AXI target configuration and observation
  int aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  logic [31:0] rdata_v = 32'h0;
  logic [1:0]  rresp_v = RESP_OKAY;
  logic [1:0]  bresp_v = RESP_OKAY;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int aw_hi = 0, w_hi = 0, valid_hi = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, b_cyc = 0;
  logic [31:0] awaddr_seen = 0, araddr_seen = 0, wdata_seen = 0;
  logic [3:0]  wstrb_seen = 0;
  logic [2:0]  awprot_seen = 0;

  // Target reacts on the falling edge; a handshake counted here is the one
  // that the following rising edge will commit.
  initial begin
    bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_arready = 0;
    bus.m_axi_bvalid = 0; bus.m_axi_bresp = 0;
    bus.m_axi_rvalid = 0; bus.m_axi_rresp = 0; bus.m_axi_rdata = 0;
    forever begin
      @(negedge clk);
      if (bus.m_axi_awvalid) begin bus.m_axi_awready = (aw_cnt == aw_lat); aw_cnt++; aw_hi++; end
      else begin bus.m_axi_awready = 0; aw_cnt = 0; end
      if (bus.m_axi_wvalid) begin bus.m_axi_wready = (w_cnt == w_lat); w_cnt++; w_hi++; end
      else begin bus.m_axi_wready = 0; w_cnt = 0; end
      if (bus.m_axi_arvalid) begin bus.m_axi_arready = (ar_cnt == ar_lat); ar_cnt++; end
      else begin bus.m_axi_arready = 0; ar_cnt = 0; end
      if (bus.m_axi_bready) begin
        bus.m_axi_bvalid = (b_cnt == b_lat); bus.m_axi_bresp = bresp_v; b_cnt++;
      end else begin bus.m_axi_bvalid = 0; b_cnt = 0; end
      if (bus.m_axi_rready) begin
        bus.m_axi_rvalid = (r_cnt == r_lat); bus.m_axi_rresp = rresp_v;
        bus.m_axi_rdata = rdata_v; r_cnt++;
      end else begin bus.m_axi_rvalid = 0; r_cnt = 0; end
      if (bus.m_axi_awvalid || bus.m_axi_wvalid || bus.m_axi_arvalid) valid_hi++;
      if (bus.m_axi_awvalid && bus.m_axi_awready) begin
        aw_hs++; awaddr_seen = bus.m_axi_awaddr; awprot_seen = bus.m_axi_awprot;
      end
      if (bus.m_axi_wvalid && bus.m_axi_wready) begin
        w_hs++; wdata_seen = bus.m_axi_wdata; wstrb_seen = bus.m_axi_wstrb;
      end
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin ar_hs++; araddr_seen = bus.m_axi_araddr; end
      if (bus.m_axi_bvalid && bus.m_axi_bready) begin b_hs++; b_cyc = cyc; end
      if (bus.m_axi_rvalid && bus.m_axi_rready) r_hs++;
    end
  end

  int t_setup = 0, t_ready = 0;

  // Called at a falling edge: that cycle is the setup phase. Returns at the
  // falling edge of the cycle in which pready is high.
  task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd,
                          output logic err, output int lat);
    int n;
    bus.s_apb_psel = 1; bus.s_apb_penable = 0; bus.s_apb_pwrite = wr;
    bus.s_apb_paddr = a; bus.s_apb_pwdata = d; bus.s_apb_pstrb = s; bus.s_apb_pprot = 3'b010;
    t_setup = cyc;
    @(negedge clk);
    bus.s_apb_penable = 1;
    n = 0;
    while (bus.s_apb_pready !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    if (bus.s_apb_pready !== 1'b1) check("pready_timeout", {31'b0, bus.s_apb_pready}, 32'd1);
    t_ready = cyc;
    lat = t_ready - t_setup;
    rd = bus.s_apb_prdata;
    err = bus.s_apb_pslverr;
  endtask

  task automatic apb_idle();
    @(negedge clk);
    bus.s_apb_psel = 0; bus.s_apb_penable = 0;
  endtask

  logic [31:0] rd;
  logic err;
  int lat, v0, first_ready;

  initial begin
    rst = 1;
    bus.s_apb_psel = 0; bus.s_apb_penable = 0; bus.s_apb_pwrite = 0;
    bus.s_apb_paddr = 0; bus.s_apb_pwdata = 0; bus.s_apb_pstrb = 0; bus.s_apb_pprot = 0;
    repeat (2) @(negedge clk);
    check("rst_pready",  {31'b0, bus.s_apb_pready},  0);
    check("rst_pslverr", {31'b0, bus.s_apb_pslverr}, 0);
    check("rst_prdata",  bus.s_apb_prdata, 0);
    check("rst_valids",  {29'b0, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid}, 0);
    check("rst_readies", {30'b0, bus.m_axi_bready, bus.m_axi_rready}, 0);
    check("rst_awaddr",  bus.m_axi_awaddr, 0);
    rst = 0;
    @(negedge clk);

    // Zero-wait read
    rdata_v = 32'hDEAD_BEEF; rresp_v = RESP_OKAY;
    apb_xfer(0, 32'h10, 0, 0, rd, err, lat);
    check("rd_lat", lat, 3);
    check("rd_data", rd, 32'hDEAD_BEEF);
    check("rd_err", {31'b0, err}, 0);
    check("rd_araddr", araddr_seen, 32'h10);
    check("rd_ar_hs", ar_hs, 1);
    apb_idle();
    check("rd_pready_pulse", {31'b0, bus.s_apb_pready}, 0);

    // Write with AW stalled
    aw_lat = 2; aw_hi = 0; w_hi = 0; b_hs = 0;
    apb_xfer(1, 32'h20, 32'h1234_5678, 4'b0101, rd, err, lat);
    check("wr_lat", lat, 5);
    check("wr_w_hi", w_hi, 1);
    check("wr_aw_hi", aw_hi, 3);
    check("wr_wstrb", {28'b0, wstrb_seen}, 32'h5);
    check("wr_wdata", wdata_seen, 32'h1234_5678);
    check("wr_awaddr", awaddr_seen, 32'h20);
    check("wr_awprot", {29'b0, awprot_seen}, 32'h2);
    check("wr_b_hs", b_hs, 1);
    check("wr_ready_after_b", t_ready, b_cyc + 1);
    check("wr_err", {31'b0, err}, 0);
    check("wr_prdata", rd, 0);
    apb_idle();
    aw_lat = 0;

    // Read with SLVERR
    rdata_v = 32'hCAFE_0000; rresp_v = RESP_SLVERR;
    apb_xfer(0, 32'h30, 0, 0, rd, err, lat);
    check("slverr_err", {31'b0, err}, 1);
    check("slverr_data", rd, 32'hCAFE_0000);
    apb_idle();
    check("slverr_clear", {31'b0, bus.s_apb_pslverr}, 0);
    rresp_v = RESP_OKAY;

    // Write with DECERR
    bresp_v = RESP_DECERR;
    apb_xfer(1, 32'h34, 32'h5555_AAAA, 4'hF, rd, err, lat);
    check("decerr_err", {31'b0, err}, 1);
    check("decerr_lat", lat, 3);
    apb_idle();
    check("decerr_clear", {31'b0, bus.s_apb_pslverr}, 0);
    bresp_v = RESP_EXOKAY;
    apb_xfer(1, 32'h38, 32'h1, 4'hF, rd, err, lat);
    check("exokay_err", {31'b0, err}, 0);
    apb_idle();
    bresp_v = RESP_OKAY;

    // Out of window
    v0 = valid_hi;
    apb_xfer(0, 32'h0002_0000, 0, 0, rd, err, lat);
    check("oow_lat", lat, 1);
    check("oow_err", {31'b0, err}, 1);
    check("oow_data", rd, 0);
    apb_idle();
    check("oow_no_axi", valid_hi, v0);

    // Reset while waiting for arready
    ar_lat = 1000;
    bus.s_apb_psel = 1; bus.s_apb_penable = 0; bus.s_apb_pwrite = 0; bus.s_apb_paddr = 32'h40;
    @(negedge clk);
    bus.s_apb_penable = 1;
    check("rstmid_arvalid_pre", {31'b0, bus.m_axi_arvalid}, 1);
    #2 rst = 1;
    #1 check("rstmid_arvalid", {31'b0, bus.m_axi_arvalid}, 0);
    bus.s_apb_psel = 0; bus.s_apb_penable = 0;
    @(negedge clk);
    rst = 0; ar_lat = 0;
    @(negedge clk);
    rdata_v = 32'h0BAD_F00D;
    apb_xfer(0, 32'h44, 0, 0, rd, err, lat);
    check("rstmid_next_lat", lat, 3);
    check("rstmid_next_data", rd, 32'h0BAD_F00D);
    check("rstmid_next_addr", araddr_seen, 32'h44);
    apb_idle();

    // Back-to-back write then read
    rdata_v = 32'h7777_1111;
    apb_xfer(1, 32'h100, 32'hA5A5_A5A5, 4'hF, rd, err, lat);
    check("b2b_wr_lat", lat, 3);
    first_ready = t_ready;
    @(negedge clk);
    apb_xfer(0, 32'h104, 0, 0, rd, err, lat);
    check("b2b_no_bubble", t_setup, first_ready + 1);
    check("b2b_rd_lat", lat, 3);
    check("b2b_rd_data", rd, 32'h7777_1111);
    check("b2b_wdata", wdata_seen, 32'hA5A5_A5A5);
    apb_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
